// File: rtl/tx_link_if.sv
// Link-controller handshake bundle: link control inputs from the LMFC/SYNC side
// and per-lane enables toward the character mux and ILA generators.
interface tx_link_if #(
  parameter int LANES  = 4,
  parameter int RCNT_W = 8
);
  logic              EN;
  logic              SYNC;
  logic              LMFC_SYNCED;
  logic [LANES-1:0]  LMFC_MS;
  logic              FRAME_STB;
  logic [LANES-1:0]  LANE_EN;
  logic              LMFC_EN;
  logic [LANES-1:0]  CGS_EN;
  logic [LANES-1:0]  ILA_EN;
  logic [LANES-1:0]  CHAR_EN;
  logic [7:0]        ILA_MF_IDX;
  logic [4:0]        STATE;
  logic [RCNT_W-1:0] RESYNC_CNT;

  modport master (
    output EN, SYNC, LMFC_SYNCED, LMFC_MS, FRAME_STB, LANE_EN,
    input  LMFC_EN, CGS_EN, ILA_EN, CHAR_EN, ILA_MF_IDX, STATE, RESYNC_CNT
  );

  modport slave (
    input  EN, SYNC, LMFC_SYNCED, LMFC_MS, FRAME_STB, LANE_EN,
    output LMFC_EN, CGS_EN, ILA_EN, CHAR_EN, ILA_MF_IDX, STATE, RESYNC_CNT
  );
endinterface

// File: rtl/tx_link_fsm.sv
// JESD204 transmit link controller: LMFC align -> CGS -> counted ILA -> DATA,
// with lane masking, SYNC-loss filtering and a saturating resync counter.
module tx_link_fsm #(
  parameter int LANES           = 4,
  parameter int ILA_MF          = 4,
  parameter int SYNC_ERR_FRAMES = 4,
  parameter int RCNT_W          = 8
) (
  input  logic       CLK,
  input  logic       RST_n,
  tx_link_if.slave   lnk
);

  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_ALIGN = 5'b00010,
    ST_CGS   = 5'b00100,
    ST_ILA   = 5'b01000,
    ST_DATA  = 5'b10000
  } state_t;

  localparam logic [7:0] ILA_LAST = 8'(ILA_MF - 1);
  localparam logic [7:0] LO_LAST  = 8'(SYNC_ERR_FRAMES - 1);

  state_t            state_r, state_s;
  logic [7:0]        ila_cnt_r, ila_cnt_s;
  logic [7:0]        lo_cnt_r, lo_cnt_s;
  logic [RCNT_W-1:0] resync_cnt_r, resync_cnt_s;
  logic              resync_ev_s;
  logic              mf_s;
  logic              link_up_s;

  assign mf_s      = |(lnk.LMFC_MS & lnk.LANE_EN);
  assign link_up_s = (state_r == ST_CGS) || (state_r == ST_ILA) || (state_r == ST_DATA);

  // Next-state and counter update, EN and LMFC loss take priority over normal flow.
  always_comb begin
    state_s      = state_r;
    ila_cnt_s    = ila_cnt_r;
    lo_cnt_s     = lo_cnt_r;
    resync_cnt_s = resync_cnt_r;
    resync_ev_s  = 1'b0;
    if (!lnk.EN) begin
      state_s = ST_IDLE;
    end else if (!lnk.LMFC_SYNCED && link_up_s) begin
      state_s = ST_ALIGN;
    end else begin
      case (state_r)
        ST_IDLE: state_s = ST_ALIGN;
        ST_ALIGN: begin
          if (lnk.LMFC_SYNCED) state_s = ST_CGS;
          else                 state_s = ST_ALIGN;
        end
        ST_CGS: begin
          if (lnk.SYNC && mf_s) begin
            state_s   = ST_ILA;
            ila_cnt_s = 8'd0;
          end else begin
            state_s = ST_CGS;
          end
        end
        ST_ILA: begin
          if (!lnk.SYNC) begin
            state_s     = ST_CGS;
            resync_ev_s = 1'b1;
          end else if (mf_s) begin
            if (ila_cnt_r == ILA_LAST) begin
              state_s  = ST_DATA;
              lo_cnt_s = 8'd0;
            end else begin
              ila_cnt_s = ila_cnt_r + 8'd1;
            end
          end else begin
            state_s = ST_ILA;
          end
        end
        ST_DATA: begin
          // Only frame-qualified SYNC-low samples advance the loss filter.
          if (lnk.SYNC) begin
            lo_cnt_s = 8'd0;
          end else if (lnk.FRAME_STB) begin
            if (lo_cnt_r == LO_LAST) begin
              state_s     = ST_CGS;
              resync_ev_s = 1'b1;
            end else begin
              lo_cnt_s = lo_cnt_r + 8'd1;
            end
          end else begin
            lo_cnt_s = lo_cnt_r;
          end
        end
        default: state_s = ST_IDLE;
      endcase
    end
    if (resync_ev_s && (resync_cnt_r != {RCNT_W{1'b1}})) begin
      resync_cnt_s = resync_cnt_r + RCNT_W'(1);
    end else begin
      resync_cnt_s = resync_cnt_r;
    end
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state_r      <= ST_IDLE;
      ila_cnt_r    <= 8'd0;
      lo_cnt_r     <= 8'd0;
      resync_cnt_r <= {RCNT_W{1'b0}};
    end else begin
      state_r      <= state_s;
      ila_cnt_r    <= ila_cnt_s;
      lo_cnt_r     <= lo_cnt_s;
      resync_cnt_r <= resync_cnt_s;
    end
  end

  assign lnk.LMFC_EN    = (state_r != ST_IDLE);
  assign lnk.CGS_EN     = {LANES{state_r == ST_CGS}}  & lnk.LANE_EN;
  assign lnk.ILA_EN     = {LANES{state_r == ST_ILA}}  & lnk.LANE_EN;
  assign lnk.CHAR_EN    = {LANES{state_r == ST_DATA}} & lnk.LANE_EN;
  assign lnk.ILA_MF_IDX = ila_cnt_r;
  assign lnk.STATE      = state_r;
  assign lnk.RESYNC_CNT = resync_cnt_r;

endmodule
